data_mem_arbiter: RTL

Two-port arbiter and sequencer for the 256-byte, byte-addressed, 64-bit-word data memory. It shares the single memory port between the pipeline MEM stage (port P) and the program/debug loader (port L). Port P has fixed priority, with a bounded-starvation guarantee for L. The block also range-checks every access and returns a registered response with a one-cycle acknowledge. It sits between the MEM stage / loader and the data memory instance.

---
 rtl/data_mem_pkg.sv | 23 ++
 rtl/data_mem_arbiter.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/data_mem_pkg.sv
// ---------------------------------------------------------------------------
// data_mem_pkg : shared types for the data-memory arbiter  |  rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package data_mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    RESP  = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_P = 1'b0,
    OWN_L = 1'b1
  } owner_t;

  localparam int unsigned DMEM_WORD_BYTES = 8;

endpackage

`default_nettype wire

// File: rtl/data_mem_arbiter.sv
// ---------------------------------------------------------------------------
// data_mem_arbiter : P/L arbiter and sequencer for the data memory  |  rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module data_mem_arbiter
  import data_mem_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 256,
  parameter int unsigned MAX_WAIT  = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        p_req_i,
  input  logic        p_we_i,
  input  logic [63:0] p_adr_i,
  input  logic [63:0] p_wdata_i,
  input  logic        l_req_i,
  input  logic        l_we_i,
  input  logic [63:0] l_adr_i,
  input  logic [63:0] l_wdata_i,
  output logic        p_ack_o,
  output logic [63:0] p_rdata_o,
  output logic        p_err_o,
  output logic        l_ack_o,
  output logic [63:0] l_rdata_o,
  output logic        l_err_o,
  output logic        p_stall_o,
  output logic [63:0] mem_adr_o,
  output logic [63:0] mem_datain_o,
  output logic        mem_w_o,
  output logic        mem_r_o,
  input  logic [63:0] mem_dataout_i
);

  localparam int unsigned LW = $clog2(MAX_WAIT + 1);
  localparam logic [LW-1:0] LWAIT_MAX = LW'(MAX_WAIT);
  localparam logic [63:0] ADR_LIMIT = 64'(MEM_BYTES - DMEM_WORD_BYTES);

  // Unsigned compare: huge addresses never wrap into low memory.
  function automatic logic in_range(input logic [63:0] adr);
    return adr <= ADR_LIMIT;
  endfunction

  arb_state_t    state_q, state_d;
  owner_t        owner_q, owner_d;
  logic [LW-1:0] lwait_q, lwait_d;
  logic          p_ack_q, p_ack_d, l_ack_q, l_ack_d;
  logic          p_err_q, p_err_d, l_err_q, l_err_d;
  logic [63:0]   p_rdata_q, p_rdata_d, l_rdata_q, l_rdata_d;

  logic          sel_we;
  logic [63:0]   sel_adr;
  logic [63:0]   sel_wdata;
  logic          sel_ok;
  logic          in_grant;

  assign sel_we    = (owner_q == OWN_L) ? l_we_i    : p_we_i;
  assign sel_adr   = (owner_q == OWN_L) ? l_adr_i   : p_adr_i;
  assign sel_wdata = (owner_q == OWN_L) ? l_wdata_i : p_wdata_i;
  assign sel_ok    = in_range(sel_adr);
  assign in_grant  = (state_q == GRANT);

  // Enables come straight from state_q, so an async reset kills them at once.
  assign mem_adr_o    = in_grant ? sel_adr   : 64'd0;
  assign mem_datain_o = in_grant ? sel_wdata : 64'd0;
  assign mem_w_o      = in_grant & sel_ok & sel_we;
  assign mem_r_o      = in_grant & sel_ok & ~sel_we;

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    lwait_d   = lwait_q;
    p_ack_d   = 1'b0;
    l_ack_d   = 1'b0;
    p_err_d   = p_err_q;
    l_err_d   = l_err_q;
    p_rdata_d = p_rdata_q;
    l_rdata_d = l_rdata_q;
    case (state_q)
      IDLE: begin
        if (p_req_i || l_req_i) begin
          state_d = GRANT;
          if (l_req_i && (!p_req_i || lwait_q == LWAIT_MAX)) begin
            owner_d = OWN_L;
            lwait_d = '0;
          end else begin
            owner_d = OWN_P;
            if (l_req_i && lwait_q != LWAIT_MAX) lwait_d = lwait_q + LW'(1);
          end
        end
      end
      GRANT: begin
        state_d = RESP;
        if (owner_q == OWN_L) begin
          l_ack_d   = 1'b1;
          l_err_d   = ~sel_ok;
          l_rdata_d = (sel_ok && !sel_we) ? mem_dataout_i : 64'd0;
        end else begin
          p_ack_d   = 1'b1;
          p_err_d   = ~sel_ok;
          p_rdata_d = (sel_ok && !sel_we) ? mem_dataout_i : 64'd0;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      owner_q   <= OWN_P;
      lwait_q   <= '0;
      p_ack_q   <= 1'b0;
      l_ack_q   <= 1'b0;
      p_err_q   <= 1'b0;
      l_err_q   <= 1'b0;
      p_rdata_q <= 64'd0;
      l_rdata_q <= 64'd0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      lwait_q   <= lwait_d;
      p_ack_q   <= p_ack_d;
      l_ack_q   <= l_ack_d;
      p_err_q   <= p_err_d;
      l_err_q   <= l_err_d;
      p_rdata_q <= p_rdata_d;
      l_rdata_q <= l_rdata_d;
    end
  end

  assign p_ack_o   = p_ack_q;
  assign l_ack_o   = l_ack_q;
  assign p_err_o   = p_err_q;
  assign l_err_o   = l_err_q;
  assign p_rdata_o = p_rdata_q;
  assign l_rdata_o = l_rdata_q;
  assign p_stall_o = p_req_i & ~p_ack_q;

endmodule

`default_nettype wire
